// File: rtl/pll_lock_rstgen.sv
// rtl/pll_lock_rstgen.sv - PLL lock qualifier and reset generator for PLL clock domains
//
// Purpose:
//   Synchronises the PLL LOCK into the free-running reference domain. Qualifies
//   LOCK over a filter window, then holds reset for a fixed holdoff before
//   releasing it. Records losses of lock that happen while running.
//
// Ports:
//   CLK         in   reference clock (PLL input clock, never a PLL output)
//   RST         in   synchronous active-high reset
//   PLL_LOCK    in   asynchronous LOCK from the PLL
//   CLR_STICKY  in   single-cycle pulse, clears LOCK_LOST and LOSS_CNT
//   RST_OUT     out  active-high reset to the PLL clock domains
//   RST_OUT_N   out  active-low copy of RST_OUT, separate flop
//   READY       out  high only while running
//   LOCK_LOST   out  sticky flag, lock dropped while running
//   LOSS_CNT    out  saturating count of run-time lock drops
//   STATE       out  FSM state: 0 WAIT_LOCK, 1 FILTER, 2 HOLDOFF, 3 RUN

module pll_lock_rstgen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_FILTER = 16,
  parameter int unsigned HOLDOFF     = 1024,
  parameter int unsigned LOSS_CNT_W  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PLL_LOCK,
  input  logic                  CLR_STICKY,
  output logic                  RST_OUT,
  output logic                  RST_OUT_N,
  output logic                  READY,
  output logic                  LOCK_LOST,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT,
  output logic [1:0]            STATE
);

  localparam int unsigned FW = $clog2(LOCK_FILTER + 1);
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  typedef enum logic [1:0] {
    S_WAIT_LOCK = 2'd0,
    S_FILTER    = 2'd1,
    S_HOLDOFF   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;

  state_t                 state_q, state_d;
  logic [FW-1:0]          fcnt_q, fcnt_d;
  logic [HW-1:0]          hcnt_q, hcnt_d;
  logic                   loss_event;

  logic                   rst_out_q, rst_out_n_q, ready_q, lock_lost_q;
  logic [LOSS_CNT_W-1:0]  loss_cnt_q;

  assign lk_s = sync_q[SYNC_STAGES-1];

  // Next-state logic. Counters default to zero so that leaving FILTER or
  // HOLDOFF for any reason restarts qualification from scratch.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = '0;
    hcnt_d     = '0;
    loss_event = 1'b0;
    case (state_q)
      S_WAIT_LOCK: begin
        if (lk_s) begin
          state_d = S_FILTER;
          fcnt_d  = FW'(1);
        end
      end
      S_FILTER: begin
        if (!lk_s) begin
          state_d = S_WAIT_LOCK;
        end else if (fcnt_q == FW'(LOCK_FILTER)) begin
          state_d = S_HOLDOFF;
          hcnt_d  = HW'(1);
        end else begin
          fcnt_d  = fcnt_q + FW'(1);
        end
      end
      S_HOLDOFF: begin
        if (!lk_s) begin
          state_d = S_WAIT_LOCK;
        end else if (hcnt_q == HW'(HOLDOFF)) begin
          state_d = S_RUN;
        end else begin
          hcnt_d  = hcnt_q + HW'(1);
        end
      end
      S_RUN: begin
        if (!lk_s) begin
          state_d    = S_WAIT_LOCK;
          loss_event = 1'b1;
        end
      end
      default: state_d = S_WAIT_LOCK;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync_q      <= '0;
      state_q     <= S_WAIT_LOCK;
      fcnt_q      <= '0;
      hcnt_q      <= '0;
      rst_out_q   <= 1'b1;
      rst_out_n_q <= 1'b0;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      loss_cnt_q  <= '0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], PLL_LOCK};
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      hcnt_q      <= hcnt_d;
      // Outputs are decoded from the state being entered so they change on
      // the same edge as the FSM, with no combinational path to the pins.
      rst_out_q   <= (state_d != S_RUN);
      rst_out_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
      // A loss on the same edge as a clear behaves as clear-then-count, so
      // the loss is never hidden by the clear.
      if (loss_event) begin
        lock_lost_q <= 1'b1;
        if (CLR_STICKY) begin
          loss_cnt_q <= LOSS_CNT_W'(1);
        end else if (!(&loss_cnt_q)) begin
          loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
      end else if (CLR_STICKY) begin
        lock_lost_q <= 1'b0;
        loss_cnt_q  <= '0;
      end
    end
  end

  assign RST_OUT   = rst_out_q;
  assign RST_OUT_N = rst_out_n_q;
  assign READY     = ready_q;
  assign LOCK_LOST = lock_lost_q;
  assign LOSS_CNT  = loss_cnt_q;
  assign STATE     = state_q;

endmodule

// File: tb/tb_pll_lock_rstgen.sv
// tb/tb_pll_lock_rstgen.sv - self-checking bench for pll_lock_rstgen

module tb_pll_lock_rstgen;

  logic       CLK;
  logic       RST;
  logic       PLL_LOCK;
  logic       CLR_STICKY;
  logic       RST_OUT;
  logic       RST_OUT_N;
  logic       READY;
  logic       LOCK_LOST;
  logic [1:0] LOSS_CNT;
  logic [1:0] STATE;

  pll_lock_rstgen #(
    .SYNC_STAGES(2),
    .LOCK_FILTER(4),
    .HOLDOFF    (8),
    .LOSS_CNT_W (2)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .PLL_LOCK  (PLL_LOCK),
    .CLR_STICKY(CLR_STICKY),
    .RST_OUT   (RST_OUT),
    .RST_OUT_N (RST_OUT_N),
    .READY     (READY),
    .LOCK_LOST (LOCK_LOST),
    .LOSS_CNT  (LOSS_CNT),
    .STATE     (STATE)
  );

  initial CLK = 1'b0;
  always #20 CLK = ~CLK;

  typedef struct {
    logic       rst;
    logic       lock;
    logic       clr;
    int         n;
    logic [1:0] st;
    logic       ro;
    logic       rdy;
    logic       lost;
    logic [1:0] cnt;
  } vec_t;

  vec_t  vq[$];
  string nq[$];
  int    checks;
  int    failures;
  bit    done;

  function automatic void add(input string nm, input logic r, input logic l,
                              input logic c, input int n, input logic [1:0] st,
                              input logic ro, input logic rdy, input logic lost,
                              input logic [1:0] cnt);
    vec_t v;
    v.rst = r; v.lock = l; v.clr = c; v.n = n;
    v.st = st; v.ro = ro; v.rdy = rdy; v.lost = lost; v.cnt = cnt;
    vq.push_back(v);
    nq.push_back(nm);
  endfunction

  function automatic logic [1:0] sat3(input int k);
    return (k > 3) ? 2'd3 : 2'(k);
  endfunction

  initial begin
    done = 1'b0;
    #1000000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: wait expired before the sequence completed");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    checks     = 0;
    failures   = 0;
    RST        = 1'b1;
    PLL_LOCK   = 1'b0;
    CLR_STICKY = 1'b0;

    repeat (5) begin
      @(posedge CLK);
      #1;
    end
    checks++;
    if (STATE !== 2'd0 || RST_OUT !== 1'b1 || RST_OUT_N !== 1'b0 ||
        READY !== 1'b0 || LOCK_LOST !== 1'b0 || LOSS_CNT !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: got state=%0d rst_out=%0b rst_out_n=%0b ready=%0b lock_lost=%0b loss_cnt=%0d",
               STATE, RST_OUT, RST_OUT_N, READY, LOCK_LOST, LOSS_CNT);
    end

    add("reset",          1, 0, 0,  5, 0, 1, 0, 0, 0);
    add("stuck_low",      0, 0, 0, 40, 0, 1, 0, 0, 0);

    add("t1_sync",        0, 1, 0,  2, 0, 1, 0, 0, 0);
    add("t1_filter",      0, 1, 0,  1, 1, 1, 0, 0, 0);
    add("t1_filter_end",  0, 1, 0,  3, 1, 1, 0, 0, 0);
    add("t1_holdoff",     0, 1, 0,  1, 2, 1, 0, 0, 0);
    add("t1_holdoff_end", 0, 1, 0,  7, 2, 1, 0, 0, 0);
    add("t1_run",         0, 1, 0,  1, 3, 0, 1, 0, 0);

    add("t2_reset",       1, 0, 0,  2, 0, 1, 0, 0, 0);
    add("t2_high",        0, 1, 0,  3, 1, 1, 0, 0, 0);
    add("t2_low",         0, 0, 0,  1, 1, 1, 0, 0, 0);
    add("t2_rise",        0, 1, 0,  1, 1, 1, 0, 0, 0);
    add("t2_restart",     0, 1, 0,  1, 0, 1, 0, 0, 0);
    add("t2_refilter",    0, 1, 0,  1, 1, 1, 0, 0, 0);
    add("t2_holdoff_end", 0, 1, 0, 11, 2, 1, 0, 0, 0);
    add("t2_run",         0, 1, 0,  1, 3, 0, 1, 0, 0);

    add("t3_reset",       1, 0, 0,  2, 0, 1, 0, 0, 0);
    add("t3_holdoff",     0, 1, 0,  8, 2, 1, 0, 0, 0);
    add("t3_fall_sync",   0, 0, 0,  2, 2, 1, 0, 0, 0);
    add("t3_drop",        0, 0, 0,  1, 0, 1, 0, 0, 0);
    add("t3_holdoff2",    0, 1, 0,  8, 2, 1, 0, 0, 0);
    add("t3_rst_holdoff", 1, 1, 0,  1, 0, 1, 0, 0, 0);
    add("t4_reset",       1, 0, 0,  2, 0, 1, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      add("t4_lock", 0, 1, 0, 15, 3, 0, 1, (i > 0), sat3(i));
      add("t4_fall", 0, 0, 0,  2, 3, 0, 1, (i > 0), sat3(i));
      add("t4_loss", 0, 0, 0,  1, 0, 1, 0, 1,       sat3(i + 1));
    end

    add("t5_lock",        0, 1, 0, 15, 3, 0, 1, 1, 3);
    add("t5_fall",        0, 0, 0,  2, 3, 0, 1, 1, 3);
    add("t5_collide",     0, 0, 1,  1, 0, 1, 0, 1, 1);
    add("t5_relock",      0, 1, 0, 15, 3, 0, 1, 1, 1);
    add("t5_clear",       0, 1, 1,  1, 3, 0, 1, 0, 0);
    add("t5_hold",        0, 1, 0,  3, 3, 0, 1, 0, 0);

    add("t6_fall",        0, 0, 0,  3, 0, 1, 0, 1, 1);
    add("t6_lock",        0, 1, 0, 15, 3, 0, 1, 1, 1);
    add("t6_reset",       1, 1, 0,  1, 0, 1, 0, 0, 0);
    add("t6_relock",      0, 1, 0, 14, 2, 1, 0, 0, 0);
    add("t6_run",         0, 1, 0,  1, 3, 0, 1, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      RST        = vq[i].rst;
      PLL_LOCK   = vq[i].lock;
      CLR_STICKY = vq[i].clr;
      repeat (vq[i].n) begin
        @(posedge CLK);
        #1;
      end
      checks++;
      if (STATE !== vq[i].st || RST_OUT !== vq[i].ro || RST_OUT_N !== ~vq[i].ro ||
          READY !== vq[i].rdy || LOCK_LOST !== vq[i].lost || LOSS_CNT !== vq[i].cnt) begin
        failures++;
        $display("FAIL row %0d %s: got state=%0d rst_out=%0b rst_out_n=%0b ready=%0b lock_lost=%0b loss_cnt=%0d; want state=%0d rst_out=%0b rst_out_n=%0b ready=%0b lock_lost=%0b loss_cnt=%0d",
                 i, nq[i], STATE, RST_OUT, RST_OUT_N, READY, LOCK_LOST, LOSS_CNT,
                 vq[i].st, vq[i].ro, ~vq[i].ro, vq[i].rdy, vq[i].lost, vq[i].cnt);
      end
    end

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
